hazard_stall_controller: RTL
============================

// Module: hazard_stall_controller
// PURPOSE
//  Generates the stall/bubble controls consumed by the pipeline's stallable pipeline registers
//  (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Detects load-use hazards, taken-branch redirects
//  and multi-cycle data-memory waits, and holds the pipeline frozen until each condition resolves.
//  Sits beside the datapath in the pipelined processor top level; one instance per core.
// PARAMETERS
//  REG_ADDR_BITS  3    width of register specifiers
//  R0_ZERO        1    1: r0 is hardwired, so a write to r0 never creates a hazard
//  MEM_TIMEOUT    255  max consecutive MEM_WAIT cycles before the error state
//  CNT_BITS       16   width of the statistics counters (only with HAZ_STATS_EN)
// PORTS
//  clk            in   1              rising-edge clock
//  rst            in   1              synchronous, active-high reset
//  id_rs1,id_rs2  in   REG_ADDR_BITS  source registers of the instruction in ID
//  id_use_rs1/2   in   1              the ID instruction actually reads rs1/rs2
//  ex_is_load     in   1              the instruction in EX is a load
//  ex_reg_write   in   1              the instruction in EX writes ex_rd
//  ex_rd          in   REG_ADDR_BITS  destination register of the EX instruction
//  ex_branch_taken in  1              branch/jump resolved taken in EX
//  mem_req        in   1              the instruction in MEM accesses data memory
//  mem_ready      in   1              data memory has completed the access this cycle
//  pc_stall       out  1              hold the PC
//  stall_if_id, stall_id_ex, stall_ex_mem  out 1 each  hold that pipeline register
//  bubble_id_ex, bubble_mem_wb        out 1 each  load a NOP into that register
//  flush_if_id    out  1              load a NOP into IF/ID
//  mem_timeout    out  1              sticky error flag
// BEHAVIOUR
//  - Registered state: RUN, MEM_WAIT, ERROR. Outputs are combinational from state and inputs,
//    so every stall takes effect in the cycle its condition is present.
//  - During rst (and on the cycle after it): state=RUN, wait counter=0, mem_timeout=0, all
//    control outputs 0.
//  - Priority, highest first: ERROR > memory wait > branch redirect > load-use.
//  - Memory wait: in RUN with mem_req & !mem_ready, assert pc_stall, stall_if_id, stall_id_ex,
//    stall_ex_mem and bubble_mem_wb; next state is MEM_WAIT with counter=1.
//    MEM_WAIT holds the same outputs while !mem_ready and increments the counter each cycle.
//    In the cycle where mem_ready=1, all outputs are 0 and the next state is RUN.
//    When the counter reaches MEM_TIMEOUT with !mem_ready, the next state is ERROR.
//    mem_req & mem_ready in RUN means a zero-wait access: no stall.
//  - ERROR: all stall outputs held at 1; mem_timeout=1; the only exit is rst.
//  - Branch (RUN only, no memory wait): ex_branch_taken asserts flush_if_id and bubble_id_ex
//    for exactly that cycle. The PC is not stalled, so the redirect target loads.
//    A load-use hazard in that same cycle is ignored, because the ID instruction is squashed.
//  - Load-use (RUN only): hazard = ex_is_load & ex_reg_write & match, where
//    match = (id_use_rs1 & rs1==ex_rd) | (id_use_rs2 & rs2==ex_rd).
//    With R0_ZERO=1, ex_rd==0 never matches.
//    Action: pc_stall, stall_if_id, bubble_id_ex for one cycle. The load advances to MEM, so
//    the hazard clears on the next cycle without any extra state.
//  - A branch held in EX during a memory wait is re-evaluated on the release cycle.
//  - Reset in MEM_WAIT or ERROR returns to RUN on the next edge.
// CONFIGURATION
//  HAZ_STATS_EN defined: adds outputs stat_loaduse, stat_branch, stat_memwait
//    (CNT_BITS each). Each counts the cycles its action was taken, saturates at all-ones, and
//    clears on rst.
//  HAZ_STATS_EN undefined: these ports and counters do not exist; all other behaviour is
//    identical.
// STRUCTURE
//  hazard_pkg: state encodings (ST_RUN/ST_MEM_WAIT/ST_ERROR) and the wait-counter width,
//    computed as clog2(MEM_TIMEOUT+1).
//  Sub-module load_use_detect: combinational comparator for the match term, parameterised by
//    REG_ADDR_BITS and R0_ZERO. The FSM, counter and output muxing live in this module.
// TESTING
//  1 ex_is_load=1, ex_rd=3, id_rs2=3, id_use_rs2=1 -> exactly 1 cycle of pc_stall, stall_if_id
//    and bubble_id_ex; 0 on the next cycle.
//  2 Same as 1 with ex_rd=0, R0_ZERO=1 -> no stall; with R0_ZERO=0 -> 1-cycle stall.
//  3 mem_req=1, mem_ready low for 4 cycles then high -> 4 stall cycles with bubble_mem_wb=1,
//    release in the ready cycle, state back in RUN.
//  4 mem_ready never asserted, MEM_TIMEOUT=8 -> ERROR after 8 wait cycles, mem_timeout=1,
//    stalls stuck until rst, then all outputs 0.
//  5 ex_branch_taken together with a load-use match -> flush_if_id=1, bubble_id_ex=1,
//    pc_stall=0; branch during a memory wait -> flush only on the release cycle.
//  6 rst asserted mid-MEM_WAIT -> next cycle RUN, all outputs 0; with HAZ_STATS_EN the
//    counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared state encodings and sizing helpers for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_e;

    // Wait counter must be able to hold the value MEM_TIMEOUT itself.
    function automatic int unsigned wait_cnt_bits(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/hazard_stall_controller_load_use_detect.sv
// Combinational source/destination register comparator for load-use hazard detection.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_BITS = 3,
    parameter int unsigned R0_ZERO       = 1
) (
    input  logic [REG_ADDR_BITS-1:0] id_rs1,
    input  logic [REG_ADDR_BITS-1:0] id_rs2,
    input  logic                     id_use_rs1,
    input  logic                     id_use_rs2,
    input  logic [REG_ADDR_BITS-1:0] ex_rd,
    output logic                     match_c
);

    always_comb begin
        match_c = (id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd));
        // A hardwired r0 never carries a real dependency.
        if ((R0_ZERO != 0) && (ex_rd == '0)) begin
            match_c = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/bubble/flush generator: load-use, taken-branch and data-memory wait handling.
// Optional per-action cycle counters are built when the HAZ_STATS_EN macro is defined.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_BITS = 3,
    parameter int unsigned R0_ZERO       = 1,
    parameter int unsigned MEM_TIMEOUT   = 255,
    parameter int unsigned CNT_BITS      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_ADDR_BITS-1:0] id_rs1,
    input  logic [REG_ADDR_BITS-1:0] id_rs2,
    input  logic                     id_use_rs1,
    input  logic                     id_use_rs2,
    input  logic                     ex_is_load,
    input  logic                     ex_reg_write,
    input  logic [REG_ADDR_BITS-1:0] ex_rd,
    input  logic                     ex_branch_taken,
    input  logic                     mem_req,
    input  logic                     mem_ready,
    output logic                     pc_stall,
    output logic                     stall_if_id,
    output logic                     stall_id_ex,
    output logic                     stall_ex_mem,
    output logic                     bubble_id_ex,
    output logic                     bubble_mem_wb,
    output logic                     flush_if_id,
    output logic                     mem_timeout
`ifdef HAZ_STATS_EN
    ,
    output logic [CNT_BITS-1:0]      stat_loaduse,
    output logic [CNT_BITS-1:0]      stat_branch,
    output logic [CNT_BITS-1:0]      stat_memwait
`endif
);

    localparam int unsigned          WCNT_BITS   = wait_cnt_bits(MEM_TIMEOUT);
    localparam logic [WCNT_BITS-1:0] TIMEOUT_VAL = WCNT_BITS'(MEM_TIMEOUT);
    localparam logic [WCNT_BITS-1:0] CNT_ONE     = WCNT_BITS'(1);

    hz_state_e            state_q, state_d;
    logic [WCNT_BITS-1:0] cnt_q, cnt_d;

    logic match_c;
    logic memwait_c, branch_c, loaduse_c, error_c;

    load_use_detect #(
        .REG_ADDR_BITS (REG_ADDR_BITS),
        .R0_ZERO       (R0_ZERO)
    ) u_load_use_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .match_c    (match_c)
    );

    // Next state, wait counter and the single action selected this cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        memwait_c = 1'b0;
        branch_c  = 1'b0;
        loaduse_c = 1'b0;
        error_c   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    memwait_c = 1'b1;
                    cnt_d     = CNT_ONE;
                    state_d   = (CNT_ONE >= TIMEOUT_VAL) ? ST_ERROR : ST_MEM_WAIT;
                end else if (ex_branch_taken) begin
                    branch_c = 1'b1;
                end else if (ex_is_load && ex_reg_write && match_c) begin
                    loaduse_c = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    memwait_c = 1'b1;
                    cnt_d     = cnt_q + CNT_ONE;
                    if (cnt_d >= TIMEOUT_VAL) begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    // Release cycle: anything held in EX/ID is evaluated as in RUN.
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    if (ex_branch_taken) begin
                        branch_c = 1'b1;
                    end else if (ex_is_load && ex_reg_write && match_c) begin
                        loaduse_c = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                error_c = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        if (rst) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            memwait_c = 1'b0;
            branch_c  = 1'b0;
            loaduse_c = 1'b0;
            error_c   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    always_comb begin
        pc_stall      = memwait_c | error_c | loaduse_c;
        stall_if_id   = memwait_c | error_c | loaduse_c;
        stall_id_ex   = memwait_c | error_c;
        stall_ex_mem  = memwait_c | error_c;
        bubble_id_ex  = branch_c | loaduse_c;
        bubble_mem_wb = memwait_c;
        flush_if_id   = branch_c;
        mem_timeout   = error_c;
    end

`ifdef HAZ_STATS_EN
    localparam logic [CNT_BITS-1:0] STAT_MAX = {CNT_BITS{1'b1}};

    logic [CNT_BITS-1:0] stat_lu_q, stat_lu_d;
    logic [CNT_BITS-1:0] stat_br_q, stat_br_d;
    logic [CNT_BITS-1:0] stat_mw_q, stat_mw_d;

    // Saturating per-action cycle counters.
    always_comb begin
        stat_lu_d = stat_lu_q;
        stat_br_d = stat_br_q;
        stat_mw_d = stat_mw_q;
        if (loaduse_c && (stat_lu_q != STAT_MAX)) stat_lu_d = stat_lu_q + CNT_BITS'(1);
        if (branch_c  && (stat_br_q != STAT_MAX)) stat_br_d = stat_br_q + CNT_BITS'(1);
        if (memwait_c && (stat_mw_q != STAT_MAX)) stat_mw_d = stat_mw_q + CNT_BITS'(1);
        if (rst) begin
            stat_lu_d = '0;
            stat_br_d = '0;
            stat_mw_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        stat_lu_q <= stat_lu_d;
        stat_br_q <= stat_br_d;
        stat_mw_q <= stat_mw_d;
    end

    assign stat_loaduse = stat_lu_q;
    assign stat_branch  = stat_br_q;
    assign stat_memwait = stat_mw_q;
`else
    logic unused_cnt_bits;
    assign unused_cnt_bits = ^32'(CNT_BITS);
`endif

endmodule
